// File: rtl/pb_operand_loader_if.sv
// Board-side bundle for the operand loader: raw buttons and switches in,
// packed operand slots and the running total out.
interface pb_operand_loader_if;
  logic [4:0]  pb;
  logic [3:0]  y;
  logic        clear;
  logic [19:0] ops;
  logic [4:0]  loaded;
  logic        all_loaded;
  logic [5:0]  sum;
  logic        carry;
  logic        upd;
  logic        busy;

  modport master (
    output pb, y, clear,
    input  ops, loaded, all_loaded, sum, carry, upd, busy
  );

  modport slave (
    input  pb, y, clear,
    output ops, loaded, all_loaded, sum, carry, upd, busy
  );
endinterface

// File: rtl/pb_operand_loader.sv
// Debounces five pushbuttons and, on each press, loads the switch value into
// the matching operand slot while keeping a running 7-bit total of all slots.
module pb_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  pb_operand_loader_if.slave bus
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, CAPTURE, ACCUM} state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  sync1;
  logic [4:0]  sync2;
  logic [4:0]  deb;
  logic [4:0]  deb_d;
  logic [4:0]  armed;
  logic [1:0]  warm;
  logic [7:0]  cnt [5];

  logic [4:0]  pending;
  logic [4:0]  rise;
  logic [4:0]  done_mask;
  logic [2:0]  lowest;
  logic [2:0]  idx;
  logic [3:0]  old;
  logic [3:0]  slots [5];
  logic [4:0]  loaded;
  logic [6:0]  total;
  logic        upd;

  // A button only counts as pressed once it has been seen released after
  // reset, so a button held through reset does not trigger a capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      armed <= '0;
      warm  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= bus.pb;
      sync2 <= sync1;
      deb_d <= deb;
      warm  <= {warm[0], 1'b1};
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LIMIT) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
        if (warm[1] && !sync2[i] && !deb[i]) armed[i] <= 1'b1;
      end
    end
  end

  assign rise      = deb & ~deb_d & armed;
  assign done_mask = (state == CAPTURE) ? (5'b00001 << idx) : 5'b00000;

  always_comb begin
    lowest = '0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) lowest = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending != 5'b00000) state_next = CAPTURE;
      CAPTURE: state_next = ACCUM;
      ACCUM:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.clear) state_next = IDLE;
  end

  // Slot write happens in CAPTURE, so ACCUM reads the freshly written value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      idx     <= '0;
      old     <= '0;
      loaded  <= '0;
      total   <= '0;
      upd     <= 1'b0;
      for (int i = 0; i < 5; i++) slots[i] <= '0;
    end else if (bus.clear) begin
      pending <= '0;
      loaded  <= '0;
      total   <= '0;
      upd     <= 1'b0;
      for (int i = 0; i < 5; i++) slots[i] <= '0;
    end else begin
      upd     <= 1'b0;
      pending <= (pending & ~done_mask) | rise;
      case (state)
        IDLE: begin
          if (pending != 5'b00000) idx <= lowest;
        end
        CAPTURE: begin
          old         <= slots[idx];
          slots[idx]  <= bus.y;
          loaded[idx] <= 1'b1;
        end
        ACCUM: begin
          total <= total - {3'b000, old} + {3'b000, slots[idx]};
          upd   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ops        = {slots[4], slots[3], slots[2], slots[1], slots[0]};
  assign bus.loaded     = loaded;
  assign bus.all_loaded = &loaded;
  assign bus.sum        = total[5:0];
  assign bus.carry      = total[6];
  assign bus.upd        = upd;
  assign bus.busy       = (state != IDLE) || (pending != 5'b00000);

endmodule

// File: tb/tb_pb_operand_loader.sv
// Directed bench for pb_operand_loader: one task per scenario, expected values
// worked out by hand from the operand values pressed in.
module tb_pb_operand_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   total_checks = 0;
  int   bad_checks = 0;
  int   cyc = 0;

  int         upd_cyc[$];
  logic [4:0] upd_loaded[$];
  logic [5:0] upd_sum[$];

  always #5 clk = ~clk;

  pb_operand_loader_if bus();

  pb_operand_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Every upd pulse is logged with the cycle it appeared in and a snapshot of
  // the outputs, so ordering and spacing can be checked afterwards.
  always @(negedge clk) begin
    if (bus.upd === 1'b1) begin
      upd_cyc.push_back(cyc);
      upd_loaded.push_back(bus.loaded);
      upd_sum.push_back(bus.sum);
    end
  end

  task automatic press(input logic [4:0] mask);
    @(negedge clk);
    bus.pb = mask;
    repeat (8) @(negedge clk);
    bus.pb = 5'b00000;
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset;
    int base;
    rst_n     = 1'b0;
    bus.pb    = 5'b11111;
    bus.y     = 4'h0;
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    total_checks++;
    if (bus.ops !== 20'h00000) begin
      bad_checks++;
      $display("[TB] FAIL reset_ops: got %h expected %h", bus.ops, 20'h00000);
    end
    total_checks++;
    if (bus.loaded !== 5'b00000) begin
      bad_checks++;
      $display("[TB] FAIL reset_loaded: got %b expected %b", bus.loaded, 5'b00000);
    end
    total_checks++;
    if (bus.sum !== 6'b000000) begin
      bad_checks++;
      $display("[TB] FAIL reset_sum: got %b expected %b", bus.sum, 6'b000000);
    end
    total_checks++;
    if ({bus.all_loaded, bus.carry, bus.upd, bus.busy} !== 4'b0000) begin
      bad_checks++;
      $display("[TB] FAIL reset_flags: got %b expected %b",
               {bus.all_loaded, bus.carry, bus.upd, bus.busy}, 4'b0000);
    end
    rst_n = 1'b1;
    base  = upd_cyc.size();
    repeat (20) @(negedge clk);
    total_checks++;
    if (bus.loaded !== 5'b00000) begin
      bad_checks++;
      $display("[TB] FAIL held_no_capture: got %b expected %b", bus.loaded, 5'b00000);
    end
    total_checks++;
    if (upd_cyc.size() - base !== 0) begin
      bad_checks++;
      $display("[TB] FAIL held_no_upd: got %0d expected %0d", upd_cyc.size() - base, 0);
    end
    bus.pb = 5'b00000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_zeros;
    int base;
    bus.y = 4'h0;
    base  = upd_cyc.size();
    for (int i = 0; i < 5; i++) press(5'(1 << i));
    total_checks++;
    if (bus.loaded !== 5'b11111) begin
      bad_checks++;
      $display("[TB] FAIL zeros_loaded: got %b expected %b", bus.loaded, 5'b11111);
    end
    total_checks++;
    if (bus.all_loaded !== 1'b1) begin
      bad_checks++;
      $display("[TB] FAIL zeros_all_loaded: got %b expected %b", bus.all_loaded, 1'b1);
    end
    total_checks++;
    if ({bus.carry, bus.sum} !== 7'd0) begin
      bad_checks++;
      $display("[TB] FAIL zeros_total: got %0d expected %0d", {bus.carry, bus.sum}, 0);
    end
    total_checks++;
    if (upd_cyc.size() - base !== 5) begin
      bad_checks++;
      $display("[TB] FAIL zeros_upd_count: got %0d expected %0d", upd_cyc.size() - base, 5);
    end
    total_checks++;
    if (bus.busy !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL zeros_busy: got %b expected %b", bus.busy, 1'b0);
    end
  endtask

  task automatic test_max;
    int base;
    bus.y = 4'hF;
    base  = upd_cyc.size();
    for (int i = 0; i < 5; i++) press(5'(1 << i));
    total_checks++;
    if (bus.sum !== 6'b001011 || bus.carry !== 1'b1) begin
      bad_checks++;
      $display("[TB] FAIL max_total: got carry=%b sum=%b expected carry=1 sum=001011",
               bus.carry, bus.sum);
    end
    total_checks++;
    if (bus.ops !== 20'hFFFFF) begin
      bad_checks++;
      $display("[TB] FAIL max_ops: got %h expected %h", bus.ops, 20'hFFFFF);
    end
    bus.y = 4'h0;
    press(5'b00100);
    total_checks++;
    if (bus.sum !== 6'b111100 || bus.carry !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL repress_total: got carry=%b sum=%b expected carry=0 sum=111100",
               bus.carry, bus.sum);
    end
    total_checks++;
    if (bus.ops !== 20'hFF0FF) begin
      bad_checks++;
      $display("[TB] FAIL repress_ops: got %h expected %h", bus.ops, 20'hFF0FF);
    end
    total_checks++;
    if (upd_cyc.size() - base !== 6) begin
      bad_checks++;
      $display("[TB] FAIL max_upd_count: got %0d expected %0d", upd_cyc.size() - base, 6);
    end
  endtask

  task automatic test_pattern;
    bus.y = 4'hA;
    for (int i = 0; i < 5; i++) press(5'(1 << i));
    total_checks++;
    if (bus.sum !== 6'b110010 || bus.carry !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL pattern_total: got carry=%b sum=%b expected carry=0 sum=110010",
               bus.carry, bus.sum);
    end
    total_checks++;
    if (bus.ops !== 20'hAAAAA) begin
      bad_checks++;
      $display("[TB] FAIL pattern_ops: got %h expected %h", bus.ops, 20'hAAAAA);
    end
  endtask

  task automatic test_simultaneous;
    int base;
    int start;
    int n;
    logic [4:0] exp_loaded [3];
    logic [5:0] exp_sum [3];
    exp_loaded = '{5'b00001, 5'b00101, 5'b10101};
    exp_sum    = '{6'd7, 6'd14, 6'd21};
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    total_checks++;
    if (bus.loaded !== 5'b00000 || bus.ops !== 20'h00000 || bus.sum !== 6'd0) begin
      bad_checks++;
      $display("[TB] FAIL clear_idle: got loaded=%b ops=%h sum=%0d expected 0/0/0",
               bus.loaded, bus.ops, bus.sum);
    end
    bus.y  = 4'd7;
    base   = upd_cyc.size();
    start  = cyc;
    bus.pb = 5'b10101;
    repeat (8) @(negedge clk);
    bus.pb = 5'b00000;
    repeat (16) @(negedge clk);
    n = upd_cyc.size() - base;
    total_checks++;
    if (n !== 3) begin
      bad_checks++;
      $display("[TB] FAIL simul_upd_count: got %0d expected %0d", n, 3);
    end
    if (n == 3) begin
      total_checks++;
      if (upd_cyc[base] - start !== 11) begin
        bad_checks++;
        $display("[TB] FAIL simul_latency: got %0d expected %0d", upd_cyc[base] - start, 11);
      end
      for (int k = 0; k < 3; k++) begin
        total_checks++;
        if (upd_loaded[base + k] !== exp_loaded[k] || upd_sum[base + k] !== exp_sum[k]) begin
          bad_checks++;
          $display("[TB] FAIL simul_order_%0d: got loaded=%b sum=%0d expected loaded=%b sum=%0d",
                   k, upd_loaded[base + k], upd_sum[base + k], exp_loaded[k], exp_sum[k]);
        end
      end
      for (int k = 1; k < 3; k++) begin
        total_checks++;
        if (upd_cyc[base + k] - upd_cyc[base + k - 1] !== 3) begin
          bad_checks++;
          $display("[TB] FAIL simul_spacing_%0d: got %0d expected %0d",
                   k, upd_cyc[base + k] - upd_cyc[base + k - 1], 3);
        end
      end
    end
    total_checks++;
    if (bus.sum !== 6'b010101 || bus.carry !== 1'b0 || bus.ops !== 20'h70707) begin
      bad_checks++;
      $display("[TB] FAIL simul_final: got carry=%b sum=%b ops=%h expected carry=0 sum=010101 ops=70707",
               bus.carry, bus.sum, bus.ops);
    end
  endtask

  task automatic test_glitch;
    int base;
    bus.y = 4'd3;
    base  = upd_cyc.size();
    @(negedge clk);
    bus.pb = 5'b00010;
    repeat (2) @(negedge clk);
    bus.pb = 5'b00000;
    repeat (20) @(negedge clk);
    total_checks++;
    if (bus.loaded !== 5'b10101 || bus.ops !== 20'h70707) begin
      bad_checks++;
      $display("[TB] FAIL glitch_capture: got loaded=%b ops=%h expected loaded=10101 ops=70707",
               bus.loaded, bus.ops);
    end
    total_checks++;
    if (upd_cyc.size() - base !== 0) begin
      bad_checks++;
      $display("[TB] FAIL glitch_upd: got %0d expected %0d", upd_cyc.size() - base, 0);
    end
  endtask

  task automatic test_clear_accum;
    int base;
    bus.y = 4'd5;
    base  = upd_cyc.size();
    @(negedge clk);
    bus.pb = 5'b00010;
    repeat (8) @(negedge clk);
    bus.pb = 5'b00000;
    repeat (2) @(negedge clk);
    total_checks++;
    if (bus.busy !== 1'b1 || bus.loaded !== 5'b10111) begin
      bad_checks++;
      $display("[TB] FAIL accum_inflight: got busy=%b loaded=%b expected busy=1 loaded=10111",
               bus.busy, bus.loaded);
    end
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    total_checks++;
    if ({bus.carry, bus.sum} !== 7'd0 || bus.loaded !== 5'b00000 || bus.ops !== 20'h00000) begin
      bad_checks++;
      $display("[TB] FAIL clear_accum: got total=%0d loaded=%b ops=%h expected 0/00000/00000",
               {bus.carry, bus.sum}, bus.loaded, bus.ops);
    end
    total_checks++;
    if (bus.upd !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL clear_accum_upd: got %b expected %b", bus.upd, 1'b0);
    end
    repeat (20) @(negedge clk);
    total_checks++;
    if (upd_cyc.size() - base !== 0 || bus.busy !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL clear_accum_quiet: got upd_count=%0d busy=%b expected 0/0",
               upd_cyc.size() - base, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_max();
    test_pattern();
    test_simultaneous();
    test_glitch();
    test_clear_accum();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
